// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - ALU with single-cycle logic ops and a shift-add multi-cycle multiplier
module mc_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  DONE,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

    // Counter value of the last shift-add step; one step per operand bit.
    localparam logic [5:0] LAST_ITER = 6'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [DATA_WIDTH-1:0]   acc;
    logic [5:0]              count;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_err;
    logic [DATA_WIDTH-1:0]   partial;

    // Single-cycle datapath; mul is handled by the sequencer, so it yields no error here.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (OPRN)
            OP_ADD: alu_res = OP1 + OP2;
            OP_SUB: alu_res = OP1 - OP2;
            OP_MUL: alu_res = '0;
            OP_SRL: alu_res = OP1 >> OP2;
            OP_SLL: alu_res = OP1 << OP2;
            OP_AND: alu_res = OP1 & OP2;
            OP_OR:  alu_res = OP1 | OP2;
            OP_NOR: alu_res = ~(OP1 | OP2);
            OP_SLT: alu_res[0] = (OP1 < OP2);
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    // Partial product contributed by the current multiplier bit.
    always_comb begin
        partial = mplier[0] ? mcand : '0;
    end

    // Control FSM: single-cycle ops complete from IDLE, mul iterates in MUL.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            RESULT <= '0;
            DONE   <= 1'b0;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (OPRN == OP_MUL) begin
                            mcand  <= OP1;
                            mplier <= OP2;
                            acc    <= '0;
                            count  <= '0;
                            BUSY   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            RESULT <= alu_res;
                            ERR    <= alu_err;
                            DONE   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 6'd1;
                    if (count == LAST_ITER) begin
                        RESULT <= acc + partial;
                        ERR    <= 1'b0;
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - randomized and directed bench for mc_alu with a behavioural model
module tb_mc_alu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [5:0]  OPRN;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [31:0] RESULT;
    logic        DONE;
    logic        BUSY;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    mc_alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
        .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    bit          model_valid = 1'b0;
    logic [31:0] m_result;
    logic        m_done, m_busy, m_err;
    logic [31:0] m_prod;
    int          m_left;

    function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        e = 1'b0;
        case (op)
            6'd1: r = a + b;
            6'd2: r = a - b;
            6'd4: r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            6'd5: r = (b >= 32) ? 32'd0 : (a << b[4:0]);
            6'd6: r = a & b;
            6'd7: r = a | b;
            6'd8: r = ~(a | b);
            6'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    always @(posedge CLK) begin
        logic [32:0] tmp;
        if (!RST) begin
            model_valid = 1'b1;
            m_result = 32'd0; m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_done = 1'b0;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_result = m_prod; m_done = 1'b1; m_busy = 1'b0; m_err = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (START) begin
                if (OPRN == 6'd3) begin
                    m_prod = OP1 * OP2;
                    m_left = 32;
                    m_busy = 1'b1;
                end else begin
                    tmp = ref_alu(OPRN, OP1, OP2);
                    m_result = tmp[31:0];
                    m_err = tmp[32];
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (model_valid) begin
            chk("cmp_result", RESULT, m_result);
            chk("cmp_done", {31'd0, DONE}, {31'd0, m_done});
            chk("cmp_busy", {31'd0, BUSY}, {31'd0, m_busy});
            chk("cmp_err", {31'd0, ERR}, {31'd0, m_err});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1; OPRN = op; OP1 = a; OP2 = b;
        cyc();
        START = 1'b0;
    endtask

    task automatic single(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        chk(name, RESULT, exp);
        chk({name, "_done"}, {31'd0, DONE}, 32'd1);
        chk({name, "_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    // Runs a mul; glitch_at > 0 drives an add request with OP1=0 at that cycle
    task automatic mul_run(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int glitch_at, input logic [31:0] exp);
        int n, bcount, dcount;
        issue(6'd3, a, b);
        n = 1;
        bcount = BUSY ? 1 : 0;
        dcount = 0;
        while (!DONE && n < 40) begin
            if (glitch_at > 0 && n == glitch_at) begin
                START = 1'b1; OPRN = 6'd1; OP1 = 32'd0;
            end else begin
                START = 1'b0;
            end
            cyc();
            n++;
            if (BUSY) bcount++;
        end
        START = 1'b0;
        if (DONE) dcount++;
        chk({name, "_cycles"}, n, 33);
        chk({name, "_busy_cycles"}, bcount, 32);
        chk({name, "_result"}, RESULT, exp);
        cyc();
        if (DONE) dcount++;
        chk({name, "_done_count"}, dcount, 1);
        chk({name, "_hold"}, RESULT, exp);
    endtask

    initial begin
        int n;
        RST = 1'b0; START = 1'b0; OPRN = 6'd0; OP1 = 32'd0; OP2 = 32'd0;
        cyc(); cyc();
        chk("rst_result", RESULT, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        RST = 1'b1;
        cyc();

        single("add", 6'h01, 32'd15, 32'd5, 32'd20);
        single("sub", 6'h02, 32'd15, 32'd5, 32'd10);
        single("srl", 6'h04, 32'd15, 32'd2, 32'd3);
        single("sll", 6'h05, 32'd15, 32'd2, 32'd60);
        cyc();
        chk("idle_done_low", {31'd0, DONE}, 32'd0);
        chk("idle_hold", RESULT, 32'd60);

        mul_run("mul15x5", 32'd15, 32'd5, 0, 32'd75);
        mul_run("mul_max", 32'hFFFF_FFFF, 32'd2, 0, 32'hFFFF_FFFE);
        mul_run("mul_glitch", 32'd15, 32'd5, 10, 32'd75);

        single("nor", 6'h08, 32'd15, 32'hFFFF_FFF0, 32'h0000_0000);
        single("slt_lt", 6'h09, 32'd15, 32'd20, 32'd1);
        single("slt_ge", 6'h09, 32'd15, 32'd5, 32'd0);
        single("sll_big", 6'h05, 32'd1, 32'd40, 32'd0);

        single("bad_op", 6'h00, 32'd15, 32'd5, 32'd0);
        chk("bad_op_err", {31'd0, ERR}, 32'd1);
        single("add_after_err", 6'h01, 32'd15, 32'd5, 32'd20);
        chk("add_clears_err", {31'd0, ERR}, 32'd0);

        // Reset in the middle of a mul, with an add waiting through reset
        issue(6'd3, 32'd15, 32'd5);
        n = 1;
        while (n < 12) begin cyc(); n++; end
        RST = 1'b0; START = 1'b1; OPRN = 6'd1; OP1 = 32'd15; OP2 = 32'd5;
        cyc();
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_result", RESULT, 32'd0);
        chk("abort_done", {31'd0, DONE}, 32'd0);
        RST = 1'b1;
        cyc();
        START = 1'b0;
        chk("post_rst_add", RESULT, 32'd20);
        chk("post_rst_done", {31'd0, DONE}, 32'd1);
        cyc();

        // Randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 600; i++) begin
            RST   = ($urandom_range(0, 149) != 0);
            START = $urandom_range(0, 1) != 0;
            OPRN  = 6'($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) OPRN = 6'($urandom_range(10, 63));
            OP1   = $urandom;
            OP2   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            cyc();
        end
        RST = 1'b1; START = 1'b0;
        for (int i = 0; i < 40; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
